// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with valid/ready handshake and a two-entry skid buffer.
// Carries LANES GPR write results plus one HI/LO write per beat. Writes to r0
// are squashed at capture and, among lanes targeting the same register, only
// the highest lane keeps its write enable.
//
// state   | meaning
// --------+---------------------------------------------
// S_EMPTY | nothing held, outputs show stale data
// S_ONE   | main register holds the head beat
// S_TWO   | main holds the head beat, skid holds the next
module mem_wb_pipe #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int LANES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*AW-1:0] mem_wd,
  input  logic [LANES-1:0]    mem_wreg,
  input  logic [LANES*DW-1:0] mem_wdata,
  input  logic                mem_whilo,
  input  logic [DW-1:0]       mem_hi,
  input  logic [DW-1:0]       mem_lo,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*AW-1:0] wb_wd,
  output logic [LANES-1:0]    wb_wreg,
  output logic [LANES*DW-1:0] wb_wdata,
  output logic                wb_whilo,
  output logic [DW-1:0]       wb_hi,
  output logic [DW-1:0]       wb_lo
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0] state_q, state_d;

  logic [LANES*AW-1:0] main_wd_q, skid_wd_q;
  logic [LANES-1:0]    main_wreg_q, skid_wreg_q;
  logic [LANES*DW-1:0] main_wdata_q, skid_wdata_q;
  logic                main_whilo_q, skid_whilo_q;
  logic [DW-1:0]       main_hi_q, skid_hi_q;
  logic [DW-1:0]       main_lo_q, skid_lo_q;

  logic [LANES-1:0] filt_wreg;
  logic             push, pop;
  logic             ld_main_in, ld_main_skid, ld_skid_in;

  // Handshake flags come only from the state flops.
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Capture filter: drop r0 writes and let the highest lane win address conflicts.
  always_comb begin
    filt_wreg = mem_wreg;
    for (int i = 0; i < LANES; i++) begin
      if (mem_wd[i*AW +: AW] == '0) filt_wreg[i] = 1'b0;
      for (int j = i + 1; j < LANES; j++) begin
        if (mem_wreg[j] && (mem_wd[j*AW +: AW] != '0) &&
            (mem_wd[j*AW +: AW] == mem_wd[i*AW +: AW]))
          filt_wreg[i] = 1'b0;
      end
    end
  end

  // Next-state and load-select decode; flush overrides every transfer.
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d    = S_ONE;
            ld_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            ld_main_in = 1'b1;
          end else if (push) begin
            state_d    = S_TWO;
            ld_skid_in = 1'b1;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d      = S_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Main register: loaded from the input or promoted from the skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_wd_q    <= '0;
      main_wreg_q  <= '0;
      main_wdata_q <= '0;
      main_whilo_q <= 1'b0;
      main_hi_q    <= '0;
      main_lo_q    <= '0;
    end else if (ld_main_in) begin
      main_wd_q    <= mem_wd;
      main_wreg_q  <= filt_wreg;
      main_wdata_q <= mem_wdata;
      main_whilo_q <= mem_whilo;
      main_hi_q    <= mem_hi;
      main_lo_q    <= mem_lo;
    end else if (ld_main_skid) begin
      main_wd_q    <= skid_wd_q;
      main_wreg_q  <= skid_wreg_q;
      main_wdata_q <= skid_wdata_q;
      main_whilo_q <= skid_whilo_q;
      main_hi_q    <= skid_hi_q;
      main_lo_q    <= skid_lo_q;
    end
  end

  // Skid register: holds the beat accepted while the main entry is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_wd_q    <= '0;
      skid_wreg_q  <= '0;
      skid_wdata_q <= '0;
      skid_whilo_q <= 1'b0;
      skid_hi_q    <= '0;
      skid_lo_q    <= '0;
    end else if (ld_skid_in) begin
      skid_wd_q    <= mem_wd;
      skid_wreg_q  <= filt_wreg;
      skid_wdata_q <= mem_wdata;
      skid_whilo_q <= mem_whilo;
      skid_hi_q    <= mem_hi;
      skid_lo_q    <= mem_lo;
    end
  end

  // Write enables are qualified by out_valid so a stale beat never writes back.
  assign wb_wd    = main_wd_q;
  assign wb_wreg  = main_wreg_q & {LANES{out_valid}};
  assign wb_wdata = main_wdata_q;
  assign wb_whilo = main_whilo_q & out_valid;
  assign wb_hi    = main_hi_q;
  assign wb_lo    = main_lo_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe (LANES = 2): directed vector table, async reset
// check, then randomized traffic against a two-deep FIFO reference model.
module tb_mem_wb_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LN = 2;

  logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [LN*AW-1:0] mem_wd, wb_wd;
  logic [LN-1:0]    mem_wreg, wb_wreg;
  logic [LN*DW-1:0] mem_wdata, wb_wdata;
  logic             mem_whilo, wb_whilo;
  logic [DW-1:0]    mem_hi, mem_lo, wb_hi, wb_lo;

  mem_wb_pipe #(.DW(DW), .AW(AW), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  wd;
    logic [1:0]  wreg;
    logic [63:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } beat_t;

  typedef struct {
    logic  fl, iv, ordy;
    beat_t b;
    logic  e_ir, e_ov;
    logic [1:0]  e_wreg;
    logic [9:0]  e_wd;
    logic [63:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi, e_lo;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  beat_t q[$];
  beat_t shown;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec rule: r0 writes dropped; on equal targets the higher lane wins.
  function automatic beat_t filt(input beat_t b);
    beat_t r = b;
    logic [4:0] a [2];
    a[0] = b.wd[4:0];
    a[1] = b.wd[9:5];
    for (int i = 0; i < 2; i++) begin
      if (a[i] == 0) r.wreg[i] = 1'b0;
      for (int j = i + 1; j < 2; j++)
        if (b.wreg[j] && a[j] != 0 && a[j] == a[i]) r.wreg[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic model_check(input string tag);
    logic v;
    v = (q.size() > 0);
    check({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".wb_wreg"},   64'(wb_wreg),   64'(v ? shown.wreg : 2'b00));
    check({tag, ".wb_whilo"},  64'(wb_whilo),  64'(v & shown.whilo));
    check({tag, ".wb_wd"},     64'(wb_wd),     64'(shown.wd));
    check({tag, ".wb_wdata"},  wb_wdata,       shown.wdata);
    check({tag, ".wb_hi"},     64'(wb_hi),     64'(shown.hi));
    check({tag, ".wb_lo"},     64'(wb_lo),     64'(shown.lo));
  endtask

  task automatic model_update(input vec_t v);
    logic rdy, vld;
    rdy = (q.size() < 2);
    vld = (q.size() > 0);
    if (v.fl) q.delete();
    else begin
      if (vld && v.ordy) void'(q.pop_front());
      if (v.iv && rdy) q.push_back(filt(v.b));
    end
    if (q.size() > 0) shown = q[0];
  endtask

  task automatic do_cycle(input vec_t v, input bit use_exp, input string tag);
    flush     = v.fl;
    in_valid  = v.iv;
    out_ready = v.ordy;
    mem_wd    = v.b.wd;
    mem_wreg  = v.b.wreg;
    mem_wdata = v.b.wdata;
    mem_whilo = v.b.whilo;
    mem_hi    = v.b.hi;
    mem_lo    = v.b.lo;
    model_check({tag, ".model"});
    model_update(v);
    @(posedge clk);
    #1;
    if (use_exp) begin
      check({tag, ".in_ready"},  64'(in_ready),  64'(v.e_ir));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(v.e_ov));
      check({tag, ".wb_wreg"},   64'(wb_wreg),   64'(v.e_wreg));
      check({tag, ".wb_wd"},     64'(wb_wd),     64'(v.e_wd));
      check({tag, ".wb_wdata"},  wb_wdata,       v.e_wdata);
      check({tag, ".wb_whilo"},  64'(wb_whilo),  64'(v.e_whilo));
      check({tag, ".wb_hi"},     64'(wb_hi),     64'(v.e_hi));
      check({tag, ".wb_lo"},     64'(wb_lo),     64'(v.e_lo));
    end
  endtask

  function automatic beat_t mkb(input logic [9:0] wd, input logic [1:0] wreg,
                                input logic [63:0] wdata, input logic whilo,
                                input logic [31:0] hi, input logic [31:0] lo);
    beat_t b;
    b.wd = wd; b.wreg = wreg; b.wdata = wdata; b.whilo = whilo; b.hi = hi; b.lo = lo;
    return b;
  endfunction

  function automatic vec_t mk(input logic fl, input logic iv, input beat_t b, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic [1:0] e_wreg,
                              input logic [9:0] e_wd, input logic [63:0] e_wdata,
                              input logic e_whilo, input logic [31:0] e_hi, input logic [31:0] e_lo);
    vec_t v;
    v.fl = fl; v.iv = iv; v.b = b; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_wreg = e_wreg; v.e_wd = e_wd;
    v.e_wdata = e_wdata; v.e_whilo = e_whilo; v.e_hi = e_hi; v.e_lo = e_lo;
    return v;
  endfunction

  localparam logic [9:0]  WA = 10'h083;  // lane0 = 3, lane1 = 4
  localparam logic [63:0] DA = 64'h00000022_00000011;
  localparam logic [9:0]  WB = 10'h0C5;  // lane0 = 5, lane1 = 6
  localparam logic [63:0] DB = 64'h00000044_00000033;
  localparam logic [9:0]  WC = 10'h128;  // lane0 = 8, lane1 = 9
  localparam logic [63:0] DC = 64'h00000066_00000055;
  localparam logic [9:0]  WF = 10'h140;  // lane0 = 0, lane1 = 10
  localparam logic [63:0] DF = 64'h00000002_00000001;
  localparam logic [9:0]  WK = 10'h0E7;  // both lanes = 7
  localparam logic [63:0] DK = 64'h000000BB_000000AA;
  localparam logic [31:0] HI = 32'hDEAD0000;
  localparam logic [31:0] LO = 32'h0000BEEF;

  vec_t tbl[20];

  initial begin
    beat_t ba, bb, bc, bf, bk, bh, bz;
    vec_t rv;

    ba = mkb(WA, 2'b11, DA, 1'b0, '0, '0);
    bb = mkb(WB, 2'b11, DB, 1'b0, '0, '0);
    bc = mkb(WC, 2'b11, DC, 1'b0, '0, '0);
    bf = mkb(WF, 2'b01, DF, 1'b0, '0, '0);
    bk = mkb(WK, 2'b11, DK, 1'b0, '0, '0);
    bh = mkb('0, 2'b00, '0, 1'b1, HI, LO);
    bz = mkb('0, 2'b00, '0, 1'b0, '0, '0);

    // streaming
    tbl[0]  = mk(0, 1, ba, 1, 1, 1, 2'b11, WA, DA, 0, '0, '0);
    tbl[1]  = mk(0, 1, bb, 1, 1, 1, 2'b11, WB, DB, 0, '0, '0);
    tbl[2]  = mk(0, 1, bc, 1, 1, 1, 2'b11, WC, DC, 0, '0, '0);
    tbl[3]  = mk(0, 0, bz, 1, 1, 0, 2'b00, WC, DC, 0, '0, '0);
    // backpressure
    tbl[4]  = mk(0, 1, ba, 0, 1, 1, 2'b11, WA, DA, 0, '0, '0);
    tbl[5]  = mk(0, 1, bb, 0, 0, 1, 2'b11, WA, DA, 0, '0, '0);
    tbl[6]  = mk(0, 1, bc, 0, 0, 1, 2'b11, WA, DA, 0, '0, '0);
    tbl[7]  = mk(0, 0, bz, 1, 1, 1, 2'b11, WB, DB, 0, '0, '0);
    tbl[8]  = mk(0, 0, bz, 1, 1, 0, 2'b00, WB, DB, 0, '0, '0);
    // filtering
    tbl[9]  = mk(0, 1, bf, 1, 1, 1, 2'b00, WF, DF, 0, '0, '0);
    tbl[10] = mk(0, 1, bk, 1, 1, 1, 2'b10, WK, DK, 0, '0, '0);
    tbl[11] = mk(0, 0, bz, 1, 1, 0, 2'b00, WK, DK, 0, '0, '0);
    // flush in TWO with a push and pop offered
    tbl[12] = mk(0, 1, ba, 0, 1, 1, 2'b11, WA, DA, 0, '0, '0);
    tbl[13] = mk(0, 1, bb, 0, 0, 1, 2'b11, WA, DA, 0, '0, '0);
    tbl[14] = mk(1, 1, bc, 1, 1, 0, 2'b00, WA, DA, 0, '0, '0);
    tbl[15] = mk(0, 0, bz, 1, 1, 0, 2'b00, WA, DA, 0, '0, '0);
    // HI/LO held under stall
    tbl[16] = mk(0, 1, bh, 0, 1, 1, 2'b00, '0, '0, 1, HI, LO);
    tbl[17] = mk(0, 0, bz, 0, 1, 1, 2'b00, '0, '0, 1, HI, LO);
    tbl[18] = mk(0, 0, bz, 0, 1, 1, 2'b00, '0, '0, 1, HI, LO);
    tbl[19] = mk(0, 0, bz, 1, 1, 0, 2'b00, '0, '0, 0, HI, LO);

    shown = bz;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mem_wd = '0; mem_wreg = '0; mem_wdata = '0; mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready",  64'(in_ready),  64'd1);
    check("reset.wb_wreg",   64'(wb_wreg),   64'd0);
    check("reset.wb_wdata",  wb_wdata,       64'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) do_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // async reset in the middle of TWO with out_ready low
    rv = mk(0, 1, mkb(WA, 2'b11, DA, 1'b1, HI, LO), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(rv, 1'b0, "pre_rst0");
    rv.b = mkb(WB, 2'b11, DB, 1'b1, LO, HI);
    do_cycle(rv, 1'b0, "pre_rst1");
    check("pre_rst.in_ready", 64'(in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.out_valid", 64'(out_valid), 64'd0);
    check("async_rst.in_ready",  64'(in_ready),  64'd1);
    check("async_rst.wb_wreg",   64'(wb_wreg),   64'd0);
    check("async_rst.wb_whilo",  64'(wb_whilo),  64'd0);
    check("async_rst.wb_wd",     64'(wb_wd),     64'd0);
    check("async_rst.wb_wdata",  wb_wdata,       64'd0);
    check("async_rst.wb_hi",     64'(wb_hi),     64'd0);
    check("async_rst.wb_lo",     64'(wb_lo),     64'd0);
    q.delete();
    shown = bz;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // randomized traffic against the FIFO model
    for (int n = 0; n < 400; n++) begin
      rv = mk(0, 0, bz, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.fl   = ($urandom_range(0, 19) == 0);
      rv.iv   = ($urandom_range(0, 3) != 0);
      rv.ordy = ($urandom_range(0, 9) < 6);
      rv.b.wd    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rv.b.wreg  = 2'($urandom);
      rv.b.wdata = {32'($urandom), 32'($urandom)};
      rv.b.whilo = 1'($urandom);
      rv.b.hi    = 32'($urandom);
      rv.b.lo    = 32'($urandom);
      do_cycle(rv, 1'b0, $sformatf("rnd%0d", n));
    end
    model_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
